// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_e : sequencer FSM states
//   clog2   : ceiling log2, used to size counters and ports from parameters
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_e;

  // Returns the smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the DDR3 clocking PLL from the free-running board clock: pulses
// the PLL reset, qualifies LOCKED, then releases downstream resets one domain
// at a time. Lock loss or lock timeout re-pulses the PLL; too many timeouts
// park the block in FAIL until soft_restart or reset.
//   clk_in1      : free-running reference clock
//   reset        : asynchronous active-high reset
//   pll_locked   : PLL LOCKED, asynchronous to clk_in1
//   soft_restart : single-cycle request to restart the whole sequence
//   pll_reset    : PLL RST, active-high
//   domain_rst   : per-domain active-high resets, released in index order
//   ready        : high only in RUN
//   error        : high only in FAIL
//   retry_count  : timeouts consumed in the current attempt
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               clk_in1,
  input  logic                               reset,
  input  logic                               pll_locked,
  input  logic                               soft_restart,
  output logic                               pll_reset,
  output logic [NUM_DOMAINS-1:0]             domain_rst,
  output logic                               ready,
  output logic                               error,
  output logic [clog2(MAX_RETRIES+1)-1:0]    retry_count
);

  localparam int RST_W = clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W  = clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GAP_W = clog2(RELEASE_GAP_CYCLES + 1);
  localparam int RTY_W = clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  logic locked_s;

  sync_2ff u_lock_sync (
    .clk (clk_in1),
    .rst (reset),
    .d   (pll_locked),
    .q   (locked_s)
  );

  state_e                 state_q, state_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]       stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;

  logic                   timeout;
  logic                   tmo_evt;
  logic                   restart;
  logic [TO_W-1:0]        to_inc;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stab_cnt_d   = stab_cnt_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    retry_d      = retry_q;
    pll_reset_d  = pll_reset_q;
    domain_rst_d = domain_rst_q;
    ready_d      = ready_q;
    error_d      = error_q;
    tmo_evt      = 1'b0;
    restart      = 1'b0;
    timeout      = (to_cnt_q == TO_LAST);
    // Saturating step: the timeout counter runs across WAIT_LOCK/STABLE
    // and must never wrap past its terminal value.
    to_inc       = timeout ? to_cnt_q : to_cnt_q + 1'b1;

    case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d     = WAIT_LOCK;
          pll_reset_d = 1'b0;
          to_cnt_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d    = STABLE;
          stab_cnt_d = '0;
          to_cnt_d   = to_inc;
        end else if (timeout) begin
          tmo_evt = 1'b1;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      STABLE: begin
        // Timeout wins over stable-count completion.
        if (timeout) begin
          tmo_evt = 1'b1;
        end else begin
          to_cnt_d = to_inc;
          if (!locked_s) begin
            state_d    = WAIT_LOCK;
            stab_cnt_d = '0;
          end else if (stab_cnt_q == STB_LAST) begin
            // Domain 0 comes out of reset on this edge.
            state_d      = RELEASE;
            gap_cnt_d    = '0;
            domain_rst_d = domain_rst_q << 1;
          end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        // Released domains are always a contiguous run from bit 0, so each
        // step is a left shift that clears the next bit up.
        if (!locked_s) begin
          restart = 1'b1;
        end else if (domain_rst_q == '0) begin
          state_d = RUN;
          ready_d = 1'b1;
          retry_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d    = '0;
          domain_rst_d = domain_rst_q << 1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      RUN: begin
        retry_d = '0;
        if (!locked_s) restart = 1'b1;
      end
      FAIL: begin
        error_d = 1'b1;
      end
      default: begin
        restart = 1'b1;
      end
    endcase

    if (tmo_evt) begin
      if (retry_q == RTY_MAX) begin
        state_d      = FAIL;
        error_d      = 1'b1;
        pll_reset_d  = 1'b1;
        domain_rst_d = '1;
      end else begin
        retry_d = retry_q + 1'b1;
        restart = 1'b1;
      end
    end

    // soft_restart overrides lock loss and timeout; inside PLL_RST it is
    // dropped so the pulse width stays fixed.
    if (soft_restart && (state_q != PLL_RST)) begin
      restart = 1'b1;
      retry_d = '0;
      error_d = 1'b0;
    end

    if (restart) begin
      state_d      = PLL_RST;
      rst_cnt_d    = '0;
      pll_reset_d  = 1'b1;
      domain_rst_d = '1;
      ready_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q      <= PLL_RST;
      rst_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      retry_q      <= retry_d;
      pll_reset_q  <= pll_reset_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign domain_rst  = domain_rst_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign retry_count = retry_q;

endmodule
